// File: rtl/stall_ctrl_if.sv
// Issue-stage stall controller bus: fetch/hazard inputs and issue outputs.
// The master side (fetch/testbench) drives fetch and hazard signals. The slave
// side (stall_ctrl) returns the comparator candidate, the PC freeze and the
// issued instruction.
interface stall_ctrl_if;
   logic [7:0]  inst_in;
   logic        inst_valid;
   logic        hazard;
   logic [7:0]  cand_inst;
   logic        pc_hold;
   logic [7:0]  issue_inst;
   logic        issue_valid;
   logic [3:0]  stall_cnt;
   logic        stall_err;
   logic [15:0] perf_bubbles;

   modport master (
      output inst_in, inst_valid, hazard,
      input  cand_inst, pc_hold, issue_inst, issue_valid, stall_cnt, stall_err, perf_bubbles
   );

   modport slave (
      input  inst_in, inst_valid, hazard,
      output cand_inst, pc_hold, issue_inst, issue_valid, stall_cnt, stall_err, perf_bubbles
   );
endinterface

// File: rtl/stall_ctrl.sv
// stall_ctrl: issue-stage stall controller.
// In RUN, a valid instruction that is flagged by the hazard comparator is
// captured. The PC and the fetch register are then frozen and bubbles are
// issued until the hazard clears. A watchdog forces release after MAX_STALL
// bubbles and sets a sticky error flag.
// Optional macro STALL_PERF_CNT_EN adds a saturating 16-bit bubble counter.
// Without the macro, perf_bubbles is tied to zero.
module stall_ctrl #(
   parameter logic [7:0] NOP_INST  = 8'b00000000,
   parameter int         MAX_STALL = 3
) (
   input logic        clock,
   input logic        reset,
   stall_ctrl_if.slave bus
);

   localparam logic [3:0] MAX_CNT = 4'(MAX_STALL);

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      STALL = 1'b1
   } state_t;

   state_t     state;
   state_t     next_state;
   logic [7:0] held_inst;
   logic [7:0] next_held;
   logic [7:0] issue_inst_reg;
   logic [7:0] issue_inst_next;
   logic       issue_valid_reg;
   logic       issue_valid_next;
   logic [3:0] stall_cnt_reg;
   logic [3:0] stall_cnt_next;
   logic       stall_err_reg;
   logic       stall_err_next;
   logic       pc_hold;
   logic [7:0] cand_inst;

   // Next-state, issue selection and combinational freeze/candidate outputs
   always_comb begin
      next_state       = state;
      next_held        = held_inst;
      issue_inst_next  = NOP_INST;
      issue_valid_next = 1'b0;
      stall_cnt_next   = stall_cnt_reg;
      stall_err_next   = stall_err_reg;
      pc_hold          = 1'b0;
      cand_inst        = bus.inst_in;
      case (state)
         RUN: begin
            cand_inst = bus.inst_in;
            if (bus.inst_valid) begin
               if (bus.hazard) begin
                  // Capture the instruction and issue the first bubble
                  next_held      = bus.inst_in;
                  stall_cnt_next = 4'd1;
                  pc_hold        = 1'b1;
                  next_state     = STALL;
               end else begin
                  issue_inst_next  = bus.inst_in;
                  issue_valid_next = 1'b1;
                  stall_cnt_next   = 4'd0;
               end
            end else begin
               // Idle slot: hazard is meaningless without a valid instruction
               stall_cnt_next = 4'd0;
            end
         end
         STALL: begin
            cand_inst = held_inst;
            if (!bus.hazard) begin
               issue_inst_next  = held_inst;
               issue_valid_next = 1'b1;
               stall_cnt_next   = 4'd0;
               next_state       = RUN;
            end else if (stall_cnt_reg < MAX_CNT) begin
               stall_cnt_next = stall_cnt_reg + 4'd1;
               pc_hold        = 1'b1;
            end else begin
               // Watchdog: hazard persisted too long, force the held instruction out
               issue_inst_next  = held_inst;
               issue_valid_next = 1'b1;
               stall_err_next   = 1'b1;
               stall_cnt_next   = 4'd0;
               next_state       = RUN;
            end
         end
         default: begin
            next_state     = RUN;
            stall_cnt_next = 4'd0;
         end
      endcase
   end

   // State and registered issue outputs with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= RUN;
         held_inst       <= NOP_INST;
         issue_inst_reg  <= NOP_INST;
         issue_valid_reg <= 1'b0;
         stall_cnt_reg   <= 4'd0;
         stall_err_reg   <= 1'b0;
      end else begin
         state           <= next_state;
         held_inst       <= next_held;
         issue_inst_reg  <= issue_inst_next;
         issue_valid_reg <= issue_valid_next;
         stall_cnt_reg   <= stall_cnt_next;
         stall_err_reg   <= stall_err_next;
      end
   end

   assign bus.cand_inst   = cand_inst;
   assign bus.pc_hold     = pc_hold;
   assign bus.issue_inst  = issue_inst_reg;
   assign bus.issue_valid = issue_valid_reg;
   assign bus.stall_cnt   = stall_cnt_reg;
   assign bus.stall_err   = stall_err_reg;

`ifdef STALL_PERF_CNT_EN
   logic [15:0] perf_cnt;

   // Saturating bubble counter. A hazard bubble is issued exactly when pc_hold is high.
   always_ff @(posedge clock) begin
      if (reset) begin
         perf_cnt <= 16'h0000;
      end else if (pc_hold && (perf_cnt != 16'hFFFF)) begin
         perf_cnt <= perf_cnt + 16'h0001;
      end else begin
         perf_cnt <= perf_cnt;
      end
   end

   assign bus.perf_bubbles = perf_cnt;
`else
   assign bus.perf_bubbles = 16'h0000;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Scoreboard bench for stall_ctrl (NOP_INST=8'h00, MAX_STALL=3).
// Stimulus pushes hand-computed expectations. The combinational outputs are
// checked in the same cycle, and the registered outputs after the next edge.
// A negedge monitor pops and compares the expectations.
module tb_stall_ctrl;

   logic clk;
   logic rst;
   int   cyc;
   int   checks;
   int   errors;
   logic [15:0] perf_exp;

   stall_ctrl_if bus ();

   stall_ctrl #(
      .NOP_INST  (8'h00),
      .MAX_STALL (3)
   ) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus.slave)
   );

   typedef struct {
      int         due;
      logic       pc;
      logic [7:0] cand;
   } comb_exp_t;

   typedef struct {
      int          due;
      logic [7:0]  ii;
      logic        iv;
      logic [3:0]  cnt;
      logic        err;
      logic [15:0] perf;
   } reg_exp_t;

   comb_exp_t comb_q[$];
   reg_exp_t  reg_q[$];
   comb_exp_t ce;
   reg_exp_t  re;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle index used to tag when each expectation becomes observable
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Monitor: compare every expectation that is due in this cycle
   always @(negedge clk) begin
      while (comb_q.size() > 0 && comb_q[0].due == cyc) begin
         ce = comb_q.pop_front();
         check("pc_hold",   {15'd0, bus.pc_hold},  {15'd0, ce.pc});
         check("cand_inst", {8'd0, bus.cand_inst}, {8'd0, ce.cand});
      end
      while (reg_q.size() > 0 && reg_q[0].due == cyc) begin
         re = reg_q.pop_front();
         check("issue_inst",   {8'd0, bus.issue_inst},  {8'd0, re.ii});
         check("issue_valid",  {15'd0, bus.issue_valid}, {15'd0, re.iv});
         check("stall_cnt",    {12'd0, bus.stall_cnt},   {12'd0, re.cnt});
         check("stall_err",    {15'd0, bus.stall_err},   {15'd0, re.err});
         check("perf_bubbles", bus.perf_bubbles,         re.perf);
      end
   end

   // One stimulus cycle: drive inputs and queue the expected responses
   task automatic step(input logic r, input logic v, input logic [7:0] inst, input logic hz,
                       input logic e_pc, input logic [7:0] e_cand,
                       input logic [7:0] e_ii, input logic e_iv, input logic [3:0] e_cnt,
                       input logic e_err, input logic bub);
      logic [15:0] perf_now;
      @(posedge clk);
      #1;
      rst            = r;
      bus.inst_valid = v;
      bus.inst_in    = inst;
      bus.hazard     = hz;
      if (!r) comb_q.push_back('{due: cyc, pc: e_pc, cand: e_cand});
      if (r) perf_exp = 16'h0000;
      else if (bub) perf_exp = perf_exp + 16'h0001;
      else perf_exp = perf_exp;
`ifdef STALL_PERF_CNT_EN
      perf_now = perf_exp;
`else
      perf_now = 16'h0000;
`endif
      reg_q.push_back('{due: cyc + 1, ii: e_ii, iv: e_iv, cnt: e_cnt, err: e_err, perf: perf_now});
   endtask

   initial begin
      cyc            = 0;
      checks         = 0;
      errors         = 0;
      perf_exp       = 16'h0000;
      rst            = 1'b1;
      bus.inst_valid = 1'b0;
      bus.inst_in    = 8'h00;
      bus.hazard     = 1'b0;

      //    r     v     inst   hz    pc    cand   ii     iv    cnt   err   bub
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0); // reset
      // Streaming with no hazard: one cycle latency, no freeze
      step(1'b0, 1'b1, 8'h47, 1'b0, 1'b0, 8'h47, 8'h47, 1'b1, 4'd0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'h92, 1'b0, 1'b0, 8'h92, 8'h92, 1'b1, 4'd0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'h13, 1'b0, 1'b0, 8'h13, 8'h13, 1'b1, 4'd0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 8'h55, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
      // Two-bubble stall on 8'h47; fetch input changes but is ignored while stalled
      step(1'b0, 1'b1, 8'h47, 1'b1, 1'b1, 8'h47, 8'h00, 1'b0, 4'd1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 8'h99, 1'b1, 1'b1, 8'h47, 8'h00, 1'b0, 4'd2, 1'b0, 1'b1);
      step(1'b0, 1'b1, 8'h99, 1'b0, 1'b0, 8'h47, 8'h47, 1'b1, 4'd0, 1'b0, 1'b0);
      // Persistent hazard: three bubbles, then a watchdog release with sticky error
      step(1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 8'h00, 1'b0, 4'd1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'hA5, 8'h00, 1'b0, 4'd2, 1'b0, 1'b1);
      step(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'hA5, 8'h00, 1'b0, 4'd3, 1'b0, 1'b1);
      step(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'hA5, 8'hA5, 1'b1, 4'd0, 1'b1, 1'b0);
      // Back-to-back hazard directly after the release; error stays set
      step(1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 8'h3C, 8'h00, 1'b0, 4'd1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h3C, 8'h3C, 1'b1, 4'd0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 8'h7E, 1'b1, 1'b1, 8'h7E, 8'h00, 1'b0, 4'd1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 8'h7E, 1'b1, 1'b1, 8'h7E, 8'h00, 1'b0, 4'd2, 1'b1, 1'b1);
      // Reset mid-stall with stall_cnt=2 clears everything, including the error
      step(1'b1, 1'b1, 8'h7E, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
      // Hazard without a valid instruction: no stall, no bubble count
      step(1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 8'h11, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 8'h22, 8'h22, 1'b1, 4'd0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);

      // Give the monitor a bounded number of cycles to drain the scoreboard
      repeat (3) @(negedge clk);
      checks++;
      if (comb_q.size() != 0 || reg_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d comb and %0d reg expectations left, required 0",
                  comb_q.size(), reg_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/stall_ctrl.md
Name: stall_ctrl

Overview:
- Issue-stage stall controller. It consumes the hazard flag produced by the pipeline hazard comparator and acts on it.
- Presents the candidate instruction to the comparator's instb input.
- Freezes the PC and the fetch register while a hazard is flagged, and injects bubble instructions into the pipeline.
- Releases the held instruction when the hazard clears. A watchdog forces release and flags an error if the hazard persists too long.

Parameters:
- NOP_INST, 8'b00000000, bubble instruction issued during a stall.
- MAX_STALL, 3, maximum consecutive bubble cycles before forced release (1..15).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- inst_in  input  8  instruction from fetch.
- inst_valid  input  1  inst_in is valid this cycle.
- hazard  input  1  comparator result for cand_inst against instm/instf; combinational, same cycle.
- cand_inst  output  8  candidate instruction driven to comparator instb: held_inst in STALL, else inst_in.
- pc_hold  output  1  combinational; freeze PC and fetch register this cycle.
- issue_inst  output  8  registered instruction entering the next pipeline stage.
- issue_valid  output  1  registered; issue_inst is a real instruction (0 for bubbles).
- stall_cnt  output  4  registered; bubbles issued in the current stall episode.
- stall_err  output  1  registered sticky flag; set on watchdog release.
- perf_bubbles  output  16  total bubble counter (see Optional Feature).

Behaviour:
- Reset (clock edge with reset=1):
  - state=RUN, held_inst=NOP_INST.
  - issue_inst=NOP_INST, issue_valid=0, stall_cnt=0, stall_err=0, perf_bubbles=0.
  - Reset mid-stall abandons the held instruction; fetch re-supplies it.
- States: RUN, STALL.
- RUN:
  - cand_inst=inst_in.
  - inst_valid=0: issue NOP_INST, issue_valid=0, pc_hold=0.
  - inst_valid=1 and hazard=0: issue_inst<=inst_in, issue_valid<=1, pc_hold=0.
  - inst_valid=1 and hazard=1: held_inst<=inst_in, issue bubble (NOP_INST, issue_valid=0), stall_cnt<=1, pc_hold=1, next=STALL.
  - hazard is ignored when inst_valid=0.
- STALL:
  - cand_inst=held_inst. inst_in and inst_valid are ignored; fetch is frozen.
  - hazard=0: issue_inst<=held_inst, issue_valid<=1, stall_cnt<=0, pc_hold=0, next=RUN.
  - hazard=1 and stall_cnt<MAX_STALL: issue bubble, stall_cnt<=stall_cnt+1, pc_hold=1, stay in STALL.
  - hazard=1 and stall_cnt==MAX_STALL (watchdog): issue held_inst with issue_valid=1, stall_err<=1, stall_cnt<=0, pc_hold=0, next=RUN.
- Timing:
  - Latency inst_in to issue_inst is 1 cycle without a hazard.
  - A stall episode adds k bubbles, 1<=k<=MAX_STALL.
- pc_hold is purely combinational from state, inst_valid, hazard and stall_cnt. It must never assert in RUN when inst_valid=0.
- stall_err clears only on reset.
- Back-to-back hazards: the instruction fetched in the release cycle may immediately re-enter STALL; there is no dead cycle.
- stall_cnt never exceeds MAX_STALL; there is no wrap.

Optional Feature:
- Macro: STALL_PERF_CNT_EN.
- Defined:
  - perf_bubbles increments by 1 on every clock edge that issues a bubble due to a hazard.
  - Idle cycles with inst_valid=0 do not count.
  - Saturates at 16'hFFFF; reset to 0.
- Undefined: perf_bubbles is tied to 16'h0000 and no counter logic is present.

Test Plan:
- Reset then stream 3 valid instructions (8'h47, 8'h92, 8'h13) with hazard=0 -> issued on consecutive cycles, one cycle late; issue_valid=1; pc_hold=0 throughout.
- inst_in=8'h47 (ori), hazard=1 for 2 cycles then 0 -> 2 bubbles (NOP_INST, issue_valid=0); cand_inst=8'h47 during the stall; pc_hold=1 for 2 cycles; 8'h47 issued on the 3rd cycle; stall_cnt goes 1,2,0.
- hazard held at 1 with MAX_STALL=3 -> 3 bubbles, then held instruction issued; stall_err=1 and remains 1 afterwards until reset.
- Reset asserted during STALL with stall_cnt=2 -> next cycle state=RUN, issue_valid=0, stall_cnt=0, pc_hold follows RUN rules.
- inst_valid=0 with hazard=1 -> no stall, pc_hold=0, issue_valid=0; the perf counter does not increment.
- STALL_PERF_CNT_EN defined, two stall episodes of 2 and 3 bubbles -> perf_bubbles=5; undefined -> perf_bubbles=0.
